adder_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `n_bit_adder` instance among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle and drives the shared adder with that pair. It registers sum, carry and requester ID into a one-deep output stage that the downstream consumer drains with its own valid/ready handshake. The block sits between the PE operand sources and the shared adder datapath.

---
 rtl/adder_rr_arbiter_if.sv | 26 ++
 rtl/adder_rr_arbiter.sv | 108 ++++++++++
 tb/tb_adder_rr_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/adder_rr_arbiter_if.sv
// adder_rr_arbiter_if: requester and result handshake bundle for adder_rr_arbiter
interface adder_rr_arbiter_if #(
    parameter int BITWIDTH = 8,
    parameter int NUM_REQ  = 4,
    parameter int IDW      = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*BITWIDTH-1:0] req_din1;
    logic [NUM_REQ*BITWIDTH-1:0] req_din2;
    logic                        res_valid;
    logic                        res_ready;
    logic [BITWIDTH-1:0]         res_dout;
    logic                        res_carry;
    logic [IDW-1:0]              res_id;

    modport master (
        output req_valid, req_din1, req_din2, res_ready,
        input  req_ready, res_valid, res_dout, res_carry, res_id
    );

    modport slave (
        input  req_valid, req_din1, req_din2, res_ready,
        output req_ready, res_valid, res_dout, res_carry, res_id
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one adder among NUM_REQ requesters; ADDER_ARB_SATURATE_EN clamps overflowing sums to all-ones
// n_bit_adder: unsigned ripple-free adder with carry-in and carry-out
module n_bit_adder #(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] din1,
    input  logic [BITWIDTH-1:0] din2,
    input  logic                cin,
    output logic [BITWIDTH-1:0] dout,
    output logic                cout
);
    assign {cout, dout} = {1'b0, din1} + {1'b0, din2} + (BITWIDTH+1)'(cin);
endmodule

module adder_rr_arbiter #(
    parameter int BITWIDTH = 8,
    parameter int NUM_REQ  = 4,
    parameter int IDW      = $clog2(NUM_REQ)
) (
    input logic               clk,
    input logic               rst_n,
    adder_rr_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state, state_next;
    logic [IDW-1:0]      ptr, ptr_next, win, id_q;
    logic [IDW:0]        idx;
    logic                found, slot_free, xfer, carry_q, cout;
    logic [BITWIDTH-1:0] a, b, sum, load, dout_q;

    assign slot_free = state == EMPTY || bus.res_ready;
    assign xfer      = rst_n && slot_free && found;
    assign ptr_next  = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    // Rotating priority search: the first valid requester at or after ptr wins
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (IDW+1)'(i);
            idx = (idx >= (IDW+1)'(NUM_REQ)) ? idx - (IDW+1)'(NUM_REQ) : idx;
            if (bus.req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    // Steer the winner's operand pair into the shared adder
    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDW'(i)) begin
                a = bus.req_din1[i*BITWIDTH +: BITWIDTH];
                b = bus.req_din2[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    n_bit_adder #(.BITWIDTH(BITWIDTH)) u_adder (
        .din1 (a),
        .din2 (b),
        .cin  (1'b0),
        .dout (sum),
        .cout (cout)
    );

`ifdef ADDER_ARB_SATURATE_EN
    assign load = cout ? '1 : sum;
`else
    assign load = sum;
`endif

    // Output stage next state: a transfer always fills it, a drain without refill empties it
    always_comb begin
        state_next = state;
        state_next = xfer ? FULL : (bus.res_ready ? EMPTY : state);
    end

    // Output stage state register
    always_ff @(posedge clk) begin
        state <= !rst_n ? EMPTY : state_next;
    end

    // Capture result and advance priority past the winner on each transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= '0;
            dout_q  <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
        end else if (xfer) begin
            ptr     <= ptr_next;
            dout_q  <= load;
            carry_q <= cout;
            id_q    <= win;
        end
    end

    assign bus.req_ready = xfer ? (NUM_REQ'(1) << win) : '0;
    assign bus.res_valid = state == FULL;
    assign bus.res_dout  = dout_q;
    assign bus.res_carry = carry_q;
    assign bus.res_id    = id_q;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: random and directed checking of adder_rr_arbiter against a queue-free behavioural model
module tb_adder_rr_arbiter;
    localparam int BW = 8;
    localparam int N  = 4;
`ifdef ADDER_ARB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    adder_rr_arbiter_if #(.BITWIDTH(BW), .NUM_REQ(N)) bif ();

    adder_rr_arbiter #(.BITWIDTH(BW), .NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the result stage must hold and whose turn it is
    int m_ptr = 0, m_id = 0, m_dout = 0, m_carry = 0;
    bit m_valid = 1'b0;

    // Every falling edge: compare DUT against the model, then advance the model over the next rising edge
    initial begin
        forever begin
            int w, best, d, s, exp_rdy;
            bit slot;
            @(negedge clk);
            w = -1;
            best = N;
            for (int i = 0; i < N; i++) begin
                d = (i - m_ptr + N) % N;
                if (bif.req_valid[i] && d < best) begin
                    best = d;
                    w = i;
                end
            end
            slot = !m_valid || bif.res_ready;
            exp_rdy = (rst_n && slot && w >= 0) ? (1 << w) : 0;
            check("m_req_ready", int'(bif.req_ready), exp_rdy);
            check("m_res_valid", int'(bif.res_valid), int'(m_valid));
            check("m_res_dout", int'(bif.res_dout), m_dout);
            check("m_res_carry", int'(bif.res_carry), m_carry);
            check("m_res_id", int'(bif.res_id), m_id);
            if (!rst_n) begin
                m_valid = 0; m_ptr = 0; m_id = 0; m_dout = 0; m_carry = 0;
            end else if (exp_rdy != 0) begin
                s = int'(bif.req_din1[w*BW +: BW]) + int'(bif.req_din2[w*BW +: BW]);
                m_carry = s >> BW;
                m_dout = (SAT && m_carry == 1) ? (1 << BW) - 1 : s % (1 << BW);
                m_id = w;
                m_valid = 1;
                m_ptr = (w + 1) % N;
            end else if (bif.res_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic rand_inputs();
        bif.req_valid = N'($urandom);
        bif.req_din1  = $urandom;
        bif.req_din2  = $urandom;
        bif.res_ready = 1'($urandom);
    endtask

    int rot_d[5] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h01};

    // Directed scenarios with hand-computed expectations, then a long random run
    initial begin
        rst_n = 1'b0;
        rand_inputs();
        repeat (3) begin
            @(posedge clk); #1;
            rand_inputs();
        end
        @(negedge clk);
        check("rst_valid", int'(bif.res_valid), 0);
        check("rst_dout", int'(bif.res_dout), 0);
        check("rst_id", int'(bif.res_id), 0);
        check("rst_ready", int'(bif.req_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bif.req_valid = 4'hF;
        bif.req_din1  = {8'h30, 8'h20, 8'h10, 8'h00};
        bif.req_din2  = {4{8'h01}};
        bif.res_ready = 1'b1;
        @(negedge clk);
        check("first_grant", int'(bif.req_ready), 4'b0001);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            @(negedge clk);
            check("rot_valid", int'(bif.res_valid), 1);
            check("rot_id", int'(bif.res_id), j % 4);
            check("rot_dout", int'(bif.res_dout), rot_d[j]);
        end
        @(posedge clk); #1;
        bif.res_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_id", int'(bif.res_id), 1);
            check("bp_dout", int'(bif.res_dout), 8'h11);
            check("bp_ready", int'(bif.req_ready), 0);
        end
        @(posedge clk); #1;
        bif.res_ready = 1'b1;
        @(negedge clk);
        check("bp_next_grant", int'(bif.req_ready), 4'b0100);
        @(posedge clk); #1;
        bif.req_valid = 4'b0001;
        bif.req_din1[7:0] = 8'hFF;
        bif.req_din2[7:0] = 8'h01;
        @(negedge clk);
        check("bp_release_id", int'(bif.res_id), 2);
        @(posedge clk); #1;
        bif.req_valid = 4'b0100;
        @(negedge clk);
        check("ovf_dout", int'(bif.res_dout), SAT ? 8'hFF : 8'h00);
        check("ovf_carry", int'(bif.res_carry), 1);
        check("ovf_id", int'(bif.res_id), 0);
        check("sparse2_ready", int'(bif.req_ready), 4'b0100);
        @(posedge clk); #1;
        bif.req_valid = 4'b0010;
        @(negedge clk);
        check("sparse2_id", int'(bif.res_id), 2);
        check("sparse1_ready", int'(bif.req_ready), 4'b0010);
        @(posedge clk); #1;
        bif.req_valid = 4'hF;
        bif.res_ready = 1'b0;
        @(negedge clk);
        check("sparse1_id", int'(bif.res_id), 1);
        check("full_ready", int'(bif.req_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bif.res_ready = 1'b1;
        @(negedge clk);
        check("midrst_valid", int'(bif.res_valid), 0);
        check("midrst_grant", int'(bif.req_ready), 4'b0001);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rand_inputs();
            bif.res_ready = ($urandom_range(3) != 0);
            rst_n = ($urandom_range(99) != 0);
        end
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
